shared_reg_arbiter: RTL and testbench

Round-robin controller that shares one WIDTH-bit D flip-flop register (data input, load enable, asynchronous reset and preset) among N_REQ requesters. Each requester asks for a load, clear, preset or read. The block grants one requester at a time and sequences the register's control strobes. It returns the register contents with a one-cycle done pulse. It sits between client logic and the flip-flop bank, and is the only driver of the bank's d/en/rst/prst pins.

---
 rtl/shared_reg_pkg.sv | 39 +++
 rtl/shared_reg_arbiter_rr_pick.sv | 34 +++
 rtl/shared_reg_arbiter.sv | 118 +++++++++++
 tb/tb_shared_reg_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register arbiter: op codes, FSM states
// and the op-to-strobe decode used when a transaction is issued.
package shared_reg_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_LOAD = 2'b00;
  localparam op_t OP_CLR  = 2'b01;
  localparam op_t OP_PRST = 2'b10;
  localparam op_t OP_READ = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_SETTLE = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  typedef struct packed {
    logic en;
    logic clr;
    logic prst;
  } strobe_t;

  // At most one field is ever set, so clear and preset can never collide.
  function automatic strobe_t decode_op(input op_t o);
    strobe_t s;
    s = '0;
    case (o)
      OP_LOAD: s.en   = 1'b1;
      OP_CLR:  s.clr  = 1'b1;
      OP_PRST: s.prst = 1'b1;
      OP_READ: s      = '0;
      default: s      = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic [PW-1:0]    win_idx,
  output logic             any
);

  always_comb begin
    int c;
    logic [PW-1:0] ci;
    c       = 0;
    ci      = '0;
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= N_REQ) c = c - N_REQ;
      ci = c[PW-1:0];
      if (!any && req[ci]) begin
        any     = 1'b1;
        win[ci] = 1'b1;
        win_idx = ci;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner of a shared WIDTH-bit flip-flop bank: grants one requester
// at a time and sequences IDLE -> ISSUE -> SETTLE -> DONE with registered outputs.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0]       reg_q,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       rdata,
  output logic                   busy,
  output logic [WIDTH-1:0]       reg_d,
  output logic                   reg_en,
  output logic                   reg_rst,
  output logic                   reg_prst
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [N_REQ-1:0] win;
  logic [PW-1:0]    win_idx;
  logic             any;
  op_t              win_op;
  logic [WIDTH-1:0] win_data;
  strobe_t          stb;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    if (int'(idx) == N_REQ - 1) return '0;
    return PW'(idx + 1'b1);
  endfunction

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  always_comb begin
    win_op   = op[2*int'(win_idx) +: 2];
    win_data = wdata[WIDTH*int'(win_idx) +: WIDTH];
    stb      = decode_op(win_op);
  end

  // Strobes are loaded on the IDLE->ISSUE edge so they are high for exactly
  // the ISSUE cycle; the async reset path drops them mid-transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      gnt      <= '0;
      done     <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      reg_d    <= '0;
      reg_en   <= 1'b0;
      reg_rst  <= 1'b0;
      reg_prst <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= '0;
          if (any) begin
            state    <= ST_ISSUE;
            gnt      <= win;
            ptr      <= next_ptr(win_idx);
            busy     <= 1'b1;
            reg_d    <= win_data;
            reg_en   <= stb.en;
            reg_rst  <= stb.clr;
            reg_prst <= stb.prst;
          end
        end
        ST_ISSUE: begin
          reg_en   <= 1'b0;
          reg_rst  <= 1'b0;
          reg_prst <= 1'b0;
          state    <= ST_SETTLE;
        end
        // reg_q has had a full cycle to settle after the strobe edge.
        ST_SETTLE: begin
          done  <= gnt;
          gnt   <= '0;
          rdata <= reg_q;
          state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          gnt      <= '0;
          done     <= '0;
          busy     <= 1'b0;
          reg_en   <= 1'b0;
          reg_rst  <= 1'b0;
          reg_prst <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin model and a behavioural register bank.
module tb_shared_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [N*W-1:0] wdata;
  logic [W-1:0]   reg_q;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   rdata, reg_d;
  logic           busy, reg_en, reg_rst, reg_prst;

  int n_vec = 0;
  int n_mis = 0;

  int       m_ptr;
  logic [W-1:0] m_q;

  logic [W-1:0] bank_q;
  logic         preload_en;
  logic [W-1:0] preload_v;

  typedef struct {
    logic [N-1:0] gnt_i;
    logic         busy_i;
    logic [2:0]   stb_i;
    logic [W-1:0] d_i;
    logic [2:0]   stb_s;
    logic [N-1:0] done_s;
    logic [N-1:0] done_d;
    logic [W-1:0] rdata_d;
    logic [N-1:0] gnt_d;
    logic [2:0]   stb_d;
    logic [N-1:0] done_e;
    logic         busy_e;
  } obs_t;

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op       (op),
    .wdata    (wdata),
    .reg_q    (reg_q),
    .gnt      (gnt),
    .done     (done),
    .rdata    (rdata),
    .busy     (busy),
    .reg_d    (reg_d),
    .reg_en   (reg_en),
    .reg_rst  (reg_rst),
    .reg_prst (reg_prst)
  );

  always #5 clk = ~clk;

  // Behavioural flip-flop bank driven by the arbiter's strobes.
  always @(posedge clk) begin
    if (preload_en)    bank_q <= preload_v;
    else if (reg_rst)  bank_q <= '0;
    else if (reg_prst) bank_q <= '1;
    else if (reg_en)   bank_q <= reg_d;
  end
  assign reg_q = bank_q;

  function automatic int m_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [2:0] m_strobe(input logic [1:0] o);
    case (o)
      2'b00:   return 3'b100;
      2'b01:   return 3'b010;
      2'b10:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [W-1:0] m_result(input logic [1:0] o, input logic [W-1:0] d,
                                            input logic [W-1:0] q);
    case (o)
      2'b00:   return d;
      2'b01:   return '0;
      2'b10:   return '1;
      default: return q;
    endcase
  endfunction

  task automatic set_op(input int i, input logic [1:0] o, input logic [W-1:0] d);
    op[2*i +: 2]  = o;
    wdata[W*i +: W] = d;
  endtask

  // Follows one transaction from the grant edge to the return to IDLE.
  task automatic observe(input bit drop, output obs_t o);
    @(posedge clk); #1;
    o.gnt_i  = gnt;
    o.busy_i = busy;
    o.stb_i  = {reg_en, reg_rst, reg_prst};
    o.d_i    = reg_d;
    if (drop) req = '0;
    @(posedge clk); #1;
    o.stb_s  = {reg_en, reg_rst, reg_prst};
    o.done_s = done;
    @(posedge clk); #1;
    o.done_d  = done;
    o.rdata_d = rdata;
    o.gnt_d   = gnt;
    o.stb_d   = {reg_en, reg_rst, reg_prst};
    @(posedge clk); #1;
    o.done_e = done;
    o.busy_e = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (gnt !== '0)   begin n_mis++; $display("FAIL reset_gnt got %b want 0", gnt); end
    n_vec++; if (done !== '0)  begin n_mis++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (rdata !== '0) begin n_mis++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_vec++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (reg_d !== '0) begin n_mis++; $display("FAIL reset_reg_d got %h want 0", reg_d); end
    n_vec++; if ({reg_en, reg_rst, reg_prst} !== 3'b000)
      begin n_mis++; $display("FAIL reset_strobes got %b want 000", {reg_en, reg_rst, reg_prst}); end
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_single_load;
    obs_t o;
    @(negedge clk);
    set_op(0, 2'b00, 8'hA5);
    req = 4'b0001;
    observe(1'b0, o);
    req = '0;
    n_vec++; if (o.gnt_i !== 4'b0001) begin n_mis++; $display("FAIL load_gnt got %b want 0001", o.gnt_i); end
    n_vec++; if (o.busy_i !== 1'b1) begin n_mis++; $display("FAIL load_busy got %b want 1", o.busy_i); end
    n_vec++; if (o.stb_i !== 3'b100) begin n_mis++; $display("FAIL load_strobe got %b want 100", o.stb_i); end
    n_vec++; if (o.d_i !== 8'hA5) begin n_mis++; $display("FAIL load_reg_d got %h want a5", o.d_i); end
    n_vec++; if (o.stb_s !== 3'b000) begin n_mis++; $display("FAIL load_settle_strobe got %b want 000", o.stb_s); end
    n_vec++; if (o.done_s !== '0) begin n_mis++; $display("FAIL load_early_done got %b want 0", o.done_s); end
    n_vec++; if (o.done_d !== 4'b0001) begin n_mis++; $display("FAIL load_done got %b want 0001", o.done_d); end
    n_vec++; if (o.rdata_d !== 8'hA5) begin n_mis++; $display("FAIL load_rdata got %h want a5", o.rdata_d); end
    n_vec++; if (o.gnt_d !== '0) begin n_mis++; $display("FAIL load_gnt_in_done got %b want 0", o.gnt_d); end
    n_vec++; if (o.done_e !== '0) begin n_mis++; $display("FAIL load_done_width got %b want 0", o.done_e); end
    n_vec++; if (o.busy_e !== 1'b0) begin n_mis++; $display("FAIL load_idle_busy got %b want 0", o.busy_e); end
    m_ptr = 1;
    m_q   = 8'hA5;
  endtask

  task automatic test_clear_preset;
    obs_t o;
    @(negedge clk);
    set_op(2, 2'b01, 8'h77);
    req = 4'b0100;
    observe(1'b0, o);
    set_op(2, 2'b10, 8'h11);
    n_vec++; if (o.gnt_i !== 4'b0100) begin n_mis++; $display("FAIL clr_gnt got %b want 0100", o.gnt_i); end
    n_vec++; if (o.stb_i !== 3'b010) begin n_mis++; $display("FAIL clr_strobe got %b want 010", o.stb_i); end
    n_vec++; if (o.rdata_d !== 8'h00) begin n_mis++; $display("FAIL clr_rdata got %h want 00", o.rdata_d); end
    n_vec++; if (o.done_d !== 4'b0100) begin n_mis++; $display("FAIL clr_done got %b want 0100", o.done_d); end
    observe(1'b0, o);
    req = '0;
    n_vec++; if (o.stb_i !== 3'b001) begin n_mis++; $display("FAIL prst_strobe got %b want 001", o.stb_i); end
    n_vec++; if (o.stb_s !== 3'b000) begin n_mis++; $display("FAIL prst_settle_strobe got %b want 000", o.stb_s); end
    n_vec++; if (o.rdata_d !== 8'hFF) begin n_mis++; $display("FAIL prst_rdata got %h want ff", o.rdata_d); end
    m_ptr = 3;
    m_q   = 8'hFF;
  endtask

  task automatic test_wrap;
    obs_t o;
    logic [W-1:0] d0, d3;
    int w;
    @(negedge clk);
    d0 = 8'($urandom);
    d3 = 8'($urandom);
    set_op(0, 2'b00, d0);
    set_op(3, 2'b00, d3);
    req = 4'b1001;
    for (int t = 0; t < 2; t++) begin
      w = m_pick(req, m_ptr);
      observe(1'b0, o);
      n_vec++; if (o.gnt_i !== (4'b0001 << w))
        begin n_mis++; $display("FAIL wrap_gnt%0d got %b want %b", t, o.gnt_i, 4'b0001 << w); end
      n_vec++; if (o.rdata_d !== ((w == 0) ? d0 : d3))
        begin n_mis++; $display("FAIL wrap_rdata%0d got %h want %h", t, o.rdata_d, (w == 0) ? d0 : d3); end
      m_ptr = (w + 1) % N;
    end
    req = '0;
    m_q = d0;
  endtask

  task automatic test_read;
    obs_t o;
    @(negedge clk);
    preload_en = 1'b1;
    preload_v  = 8'h3C;
    @(negedge clk);
    preload_en = 1'b0;
    m_q = 8'h3C;
    set_op(1, 2'b11, 8'h99);
    req = 4'b0010;
    observe(1'b0, o);
    req = '0;
    n_vec++; if (o.gnt_i !== 4'b0010) begin n_mis++; $display("FAIL read_gnt got %b want 0010", o.gnt_i); end
    n_vec++; if ((o.stb_i | o.stb_s | o.stb_d) !== 3'b000)
      begin n_mis++; $display("FAIL read_strobe got %b want 000", o.stb_i | o.stb_s | o.stb_d); end
    n_vec++; if (o.rdata_d !== 8'h3C) begin n_mis++; $display("FAIL read_rdata got %h want 3c", o.rdata_d); end
    n_vec++; if (o.done_d !== 4'b0010) begin n_mis++; $display("FAIL read_done got %b want 0010", o.done_d); end
    m_ptr = 2;
  endtask

  task automatic test_fairness;
    obs_t o;
    logic [W-1:0] d;
    int w;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) set_op(i, 2'b00, 8'($urandom));
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      w = m_pick(req, m_ptr);
      d = wdata[W*w +: W];
      observe(1'b0, o);
      n_vec++; if (o.gnt_i !== (4'b0001 << w))
        begin n_mis++; $display("FAIL rr_gnt%0d got %b want %b", t, o.gnt_i, 4'b0001 << w); end
      n_vec++; if (o.rdata_d !== d)
        begin n_mis++; $display("FAIL rr_rdata%0d got %h want %h", t, o.rdata_d, d); end
      m_ptr = (w + 1) % N;
      m_q   = d;
      set_op(w, 2'b00, 8'($urandom));
    end
    req = '0;
  endtask

  task automatic test_reset_mid;
    obs_t o;
    logic [W-1:0] d;
    @(negedge clk);
    set_op(2, 2'b00, 8'h5A);
    req = 4'b0100;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b1) begin n_mis++; $display("FAIL mid_busy_before got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_vec++; if ({gnt, done, busy, reg_en, reg_rst, reg_prst} !== '0)
      begin n_mis++; $display("FAIL mid_async_clear got gnt=%b done=%b busy=%b stb=%b want all 0",
                              gnt, done, busy, {reg_en, reg_rst, reg_prst}); end
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      n_vec++; if (done !== '0) begin n_mis++; $display("FAIL mid_no_done%0d got %b want 0", t, done); end
    end
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
    m_q   = 8'h5A;
    d = 8'($urandom);
    set_op(2, 2'b00, d);
    set_op(3, 2'b00, 8'($urandom));
    req = 4'b1100;
    observe(1'b0, o);
    req = '0;
    n_vec++; if (o.gnt_i !== 4'b0100) begin n_mis++; $display("FAIL mid_ptr_reset got %b want 0100", o.gnt_i); end
    n_vec++; if (o.rdata_d !== d) begin n_mis++; $display("FAIL mid_next_rdata got %h want %h", o.rdata_d, d); end
    m_ptr = 3;
    m_q   = d;
  endtask

  task automatic test_random;
    obs_t o;
    logic [1:0]   wop;
    logic [W-1:0] wd, exp_q;
    logic [N-1:0] r;
    bit drop;
    int w;
    for (int t = 0; t < 40; t++) begin
      r = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) set_op(i, 2'($urandom_range(0, 3)), 8'($urandom));
      req  = r;
      drop = ($urandom_range(0, 3) == 0);
      w     = m_pick(r, m_ptr);
      wop   = op[2*w +: 2];
      wd    = wdata[W*w +: W];
      exp_q = m_result(wop, wd, m_q);
      observe(drop, o);
      req = '0;
      n_vec++; if (o.gnt_i !== (4'b0001 << w))
        begin n_mis++; $display("FAIL rnd_gnt%0d got %b want %b", t, o.gnt_i, 4'b0001 << w); end
      n_vec++; if (o.stb_i !== m_strobe(wop))
        begin n_mis++; $display("FAIL rnd_strobe%0d got %b want %b", t, o.stb_i, m_strobe(wop)); end
      n_vec++; if ((o.stb_s | o.stb_d) !== 3'b000)
        begin n_mis++; $display("FAIL rnd_late_strobe%0d got %b want 000", t, o.stb_s | o.stb_d); end
      n_vec++; if (o.done_d !== (4'b0001 << w))
        begin n_mis++; $display("FAIL rnd_done%0d got %b want %b drop=%0d", t, o.done_d, 4'b0001 << w, drop); end
      n_vec++; if (o.rdata_d !== exp_q)
        begin n_mis++; $display("FAIL rnd_rdata%0d got %h want %h", t, o.rdata_d, exp_q); end
      n_vec++; if ({o.done_e, o.busy_e} !== '0)
        begin n_mis++; $display("FAIL rnd_idle%0d got done=%b busy=%b want 0", t, o.done_e, o.busy_e); end
      m_ptr = (w + 1) % N;
      m_q   = exp_q;
    end
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    op         = '0;
    wdata      = '0;
    preload_en = 1'b0;
    preload_v  = '0;
    m_ptr      = 0;
    m_q        = '0;
    test_reset();
    test_single_load();
    test_clear_preset();
    test_wrap();
    test_read();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
